ad79x8_responder: RTL and testbench
===================================

Name: ad79x8_responder

Overview:
- Synthesizable SPI-slave model of an AD7908/AD7918/AD7928 8-channel ADC, the device side of the ad79x8 serial link.
- Receives the 16-bit control frame on din, returns {0, ADD[2:0], data} on dout, and runs the device channel sequencer.
- Sample values come from a parallel per-channel bus, so it serves as a bench/loopback stand-in for the physical ADC and as an FPGA-resident ADC emulator.
- Clocked directly by the serial clock; no oversampling.

Parameters:
RES_BITS, 12, converter resolution (12 = AD7928, 10 = AD7918, 8 = AD7908); left-justified in a 12-bit field, unused LSBs driven 0
NUM_CH, 8, channel count; fixed at 8 (3-bit address), present for package checks only

Ports:
sclk  in  1  serial clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
cs  in  1  active-low chip select, sampled on rising sclk
din  in  1  control bit stream, MSB first, sampled on rising sclk
dout  out  1  result bit stream, MSB first
dout_en  out  1  1 while cs low; tristate enable for a pad wrapper
ch_data  in  8*RES_BITS  channel samples, ch n at [n*RES_BITS +: RES_BITS], sampled at frame end
ctrl_reg  out  12  current control register
cur_channel  out  3  channel whose result is loaded for the next frame
frame_done  out  1  one-cycle pulse on the 16th rising edge of a frame

Behaviour:
- Reset values: ctrl_reg = 12'h031 (WRITE0 SEQ0 ADD000 PM11 SHADOW0 RANGE0 CODING1); tx_shift = 16'h0000; bit_cnt = 0; cur_channel = 0; seq_active = 0; seq_last = 0; frame_done = 0. Outputs: dout = 0, dout_en = 0.
- Reset is asynchronous and may assert mid-frame. The partial frame is discarded, and the next frame begins only after cs is sampled high and then low again.
- dout = tx_shift[15] & ~cs, combinational. dout_en = ~cs. Bit 15 is valid as soon as cs falls. tx_shift shifts left once per rising edge with cs low, so each bit is stable across the following falling edge, where the master samples it.
- Rising edge with cs low: rx_shift <= {rx_shift[14:0], din}, and bit_cnt increments.
- On the rising edge where bit_cnt == 15 (the 16th edge), with rx = {rx_shift[14:0], din}:
  - The control word is rx[15:4]; rx[3:0] is ignored.
  - If WRITE (bit 11) = 1, ctrl_reg <= control word. Otherwise ctrl_reg is held.
  - The next channel is selected per the sequencer rules below.
  - tx_shift <= {1'b0, nxt[2:0], fmt(ch_data[nxt])}.
  - frame_done <= 1, and bit_cnt wraps to 0.
- A cs=1 sample on a rising edge sets bit_cnt = 0. If the frame was partial, it is aborted: no ctrl_reg, sequencer or tx_shift update, and no frame_done. tx_shift is restored to the last loaded word (a held copy) so the result is resent.
- Sequencer, evaluated on frame end:
  - WRITE=1, SEQ=0: nxt = ADD; seq_active = 0.
  - WRITE=1, SEQ=1, SHADOW=0: seq_active = 1, seq_last = ADD, nxt = 0. This also restarts a sequence already running.
  - WRITE=1, SHADOW=1 (shadow modes): unsupported; treated as WRITE=1, SEQ=0.
  - WRITE=0, seq_active=1: nxt = 0 if cur_channel == seq_last, else cur_channel + 1.
  - WRITE=0, seq_active=0: nxt = cur_channel (repeat).
  - cur_channel <= nxt.
- fmt, using the post-update ctrl_reg:
  - PM = 10 (full shutdown): data field = 0.
  - Otherwise: sample, with the MSB inverted when CODING = 0 (two's complement), left-justified to 12 bits, zero-padded.
- Frames longer than 16 edges: the 17th edge starts a new frame and dout shows the new word. Masters must deassert cs.

Decomposition:
- ad79x8_pkg holds:
  - control bit indices: WRITE=11, SEQ=10, ADD=8:6, PM=5:4, SHADOW=3, RANGE=1, CODING=0
  - PM encodings: NORMAL=2'b11, AUTO_SD=2'b01, FULL_SD=2'b10
  - CTRL_RST = 12'h031
  - FRAME_BITS = 16
- Sub-module ad79x8_sequencer: combinational next-channel logic plus the seq_active/seq_last registers. The top level keeps the shift registers, the counter and fmt.

Test Plan:
1. Reset, then a frame with din all 0 -> dout bits 16'h0000, ctrl_reg = 12'h031, frame_done pulses once on edge 16.
2. Frame din = 16'h9710 (WRITE, ADD=5, PM11, CODING1) with ch5 = 12'hABC, then a frame with din = 0 -> second frame dout = 16'h5ABC, cur_channel = 5.
3. Frame din = 16'h9700 (CODING0) with ch5 = 12'hABC -> next dout = 16'h52BC. Repeat with RES_BITS=8 and ch5 = 8'hAB -> 16'h52B0.
4. Frame din = 16'hCB10 (SEQ, ADD=2), then five frames with din = 0 -> dout address fields 0,1,2,0,1 from the following frame onward.
5. cs raised after 8 edges during a frame carrying 16'h9710 -> ctrl_reg unchanged, no frame_done; the next full frame returns the previous word again.
6. rst_n pulsed low at edge 10 of a frame -> ctrl_reg = 12'h031, dout_en = 0, bit_cnt = 0 immediately; the next frame behaves as scenario 1.

Source files
------------

// File: rtl/ad79x8_pkg.sv
// Shared constants and types for the AD79x8 SPI-slave responder.
package ad79x8_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CTRL_BITS  = 12;
    localparam int unsigned TAIL_BITS  = FRAME_BITS - CTRL_BITS;
    localparam int unsigned ADDR_BITS  = 3;
    localparam int unsigned DATA_BITS  = 12;
    localparam int unsigned CNT_BITS   = 4;

    // Control register bit positions
    localparam int unsigned BIT_WRITE  = 11;
    localparam int unsigned BIT_SEQ    = 10;
    localparam int unsigned BIT_ADD_HI = 8;
    localparam int unsigned BIT_ADD_LO = 6;
    localparam int unsigned BIT_PM_HI  = 5;
    localparam int unsigned BIT_PM_LO  = 4;
    localparam int unsigned BIT_SHADOW = 3;
    localparam int unsigned BIT_RANGE  = 1;
    localparam int unsigned BIT_CODING = 0;

    typedef enum logic [1:0] {
        PM_AUTO_SD = 2'b01,
        PM_FULL_SD = 2'b10,
        PM_NORMAL  = 2'b11
    } pm_e;

    localparam logic [CTRL_BITS-1:0] CTRL_RST = 12'h031;

    // Result word as shifted out on dout
    typedef struct packed {
        logic                 zero;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } tx_word_t;

    // SYNC: waiting for cs high after reset before accepting a frame
    typedef enum logic {
        ST_SYNC  = 1'b0,
        ST_READY = 1'b1
    } link_state_e;

endpackage

// File: rtl/ad79x8_sequencer.sv
// Channel sequencer: picks the channel to convert for the next frame.
module ad79x8_sequencer
    import ad79x8_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_end,
    input  logic                 write,
    input  logic                 seq,
    input  logic                 shadow,
    input  logic [ADDR_BITS-1:0] add,
    input  logic [ADDR_BITS-1:0] cur_channel,
    output logic [ADDR_BITS-1:0] nxt_channel_c
);

    logic                 seq_active;
    logic [ADDR_BITS-1:0] seq_last;
    logic                 start_seq_c;

    // Shadow modes are not modelled; they fall back to a plain addressed write
    assign start_seq_c = write & seq & ~shadow;

    always_comb begin
        nxt_channel_c = cur_channel;
        if (start_seq_c) begin
            nxt_channel_c = '0;
        end else if (write) begin
            nxt_channel_c = add;
        end else if (seq_active) begin
            nxt_channel_c = (cur_channel == seq_last) ? '0 : cur_channel + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_active <= 1'b0;
            seq_last   <= '0;
        end else if (frame_end) begin
            if (start_seq_c) begin
                seq_active <= 1'b1;
                seq_last   <= add;
            end else if (write) begin
                seq_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ad79x8_responder.sv
// Device-side AD7908/AD7918/AD7928 serial model: control frame in, result word out,
// sample values taken from a parallel per-channel bus.
module ad79x8_responder
    import ad79x8_pkg::*;
#(
    parameter int unsigned RES_BITS = 12,
    parameter int unsigned NUM_CH   = 8
) (
    input  logic                       sclk,
    input  logic                       rst_n,
    input  logic                       cs,
    input  logic                       din,
    output logic                       dout,
    output logic                       dout_en,
    input  logic [NUM_CH*RES_BITS-1:0] ch_data,
    output logic [CTRL_BITS-1:0]       ctrl_reg,
    output logic [ADDR_BITS-1:0]       cur_channel,
    output logic                       frame_done
);

    localparam int unsigned PAD_BITS = DATA_BITS - RES_BITS;

    link_state_e           state;
    link_state_e           state_nxt;
    logic                  shift_en;
    logic                  frame_end;

    logic [FRAME_BITS-2:0] rx_shift;
    logic [FRAME_BITS-1:0] rx_c;
    logic [CNT_BITS-1:0]   bit_cnt;
    logic [FRAME_BITS-1:0] tx_shift;
    logic [FRAME_BITS-1:0] tx_hold;
    logic [CTRL_BITS-1:0]  ctrl_q;
    logic [CTRL_BITS-1:0]  ctrl_rx;
    logic [CTRL_BITS-1:0]  ctrl_nxt;
    logic [ADDR_BITS-1:0]  nxt_ch_c;
    logic                  rx_tail_unused;

    logic [RES_BITS-1:0]   samples [NUM_CH];
    logic [RES_BITS-1:0]   sample_sel;
    logic [DATA_BITS-1:0]  data_fmt;
    tx_word_t              tx_load;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_unpack
        assign samples[n] = ch_data[n*RES_BITS +: RES_BITS];
    end

    // Frame-level word as it stands on the edge being evaluated
    assign rx_c           = {rx_shift, din};
    assign ctrl_rx        = rx_c[FRAME_BITS-1 -: CTRL_BITS];
    assign rx_tail_unused = ^rx_c[TAIL_BITS-1:0];
    assign ctrl_nxt       = ctrl_rx[BIT_WRITE] ? ctrl_rx : ctrl_q;
    assign ctrl_reg       = ctrl_q;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        frame_end = 1'b0;
        dout_en   = 1'b0;
        dout      = 1'b0;
        case (state)
            ST_SYNC: begin
                if (cs) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                shift_en  = ~cs;
                frame_end = ~cs && (bit_cnt == CNT_BITS'(FRAME_BITS - 1));
                dout_en   = ~cs;
                dout      = tx_shift[FRAME_BITS-1] & ~cs;
            end
            default: state_nxt = ST_SYNC;
        endcase
    end

    ad79x8_sequencer u_seq (
        .clk           (sclk),
        .rst_n         (rst_n),
        .frame_end     (frame_end),
        .write         (ctrl_rx[BIT_WRITE]),
        .seq           (ctrl_rx[BIT_SEQ]),
        .shadow        (ctrl_rx[BIT_SHADOW]),
        .add           (ctrl_rx[BIT_ADD_HI:BIT_ADD_LO]),
        .cur_channel   (cur_channel),
        .nxt_channel_c (nxt_ch_c)
    );

    // Result formatting uses the control word that takes effect at this frame end
    always_comb begin
        sample_sel = samples[nxt_ch_c];
        if (!ctrl_nxt[BIT_CODING]) begin
            sample_sel[RES_BITS-1] = ~sample_sel[RES_BITS-1];
        end
        data_fmt = DATA_BITS'(sample_sel) << PAD_BITS;
        if (ctrl_nxt[BIT_PM_HI:BIT_PM_LO] == PM_FULL_SD) begin
            data_fmt = '0;
        end
        tx_load.zero = 1'b0;
        tx_load.addr = nxt_ch_c;
        tx_load.data = data_fmt;
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift    <= '0;
            bit_cnt     <= '0;
            tx_shift    <= '0;
            tx_hold     <= '0;
            ctrl_q      <= CTRL_RST;
            cur_channel <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (shift_en) begin
                rx_shift <= rx_c[FRAME_BITS-2:0];
                if (frame_end) begin
                    bit_cnt     <= '0;
                    ctrl_q      <= ctrl_nxt;
                    cur_channel <= nxt_ch_c;
                    tx_shift    <= tx_load;
                    tx_hold     <= tx_load;
                    frame_done  <= 1'b1;
                end else begin
                    bit_cnt  <= bit_cnt + 1'b1;
                    tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
                end
            end else if (state == ST_READY) begin
                // cs high: drop any partial frame and re-arm the pending result
                bit_cnt  <= '0;
                tx_shift <= tx_hold;
            end
        end
    end

endmodule

// File: tb/tb_ad79x8_responder.sv
// Bench for ad79x8_responder: frame-level reference model plus directed frames,
// run against a 12-bit and an 8-bit instance sharing one serial link.
module tb_ad79x8_responder;

    localparam int unsigned NCH = 8;

    logic sclk = 1'b0;
    logic rst_n;
    logic cs;
    logic din;
    logic [NCH*12-1:0] ch_data12;
    logic [NCH*8-1:0]  ch_data8;

    logic        dout12, dout_en12, fd12;
    logic [11:0] ctrl12;
    logic [2:0]  cur12;
    logic        dout8, dout_en8, fd8;
    logic [11:0] ctrl8;
    logic [2:0]  cur8;

    always #5 sclk = ~sclk;

    ad79x8_responder #(.RES_BITS(12), .NUM_CH(8)) dut12 (
        .sclk(sclk), .rst_n(rst_n), .cs(cs), .din(din), .dout(dout12), .dout_en(dout_en12),
        .ch_data(ch_data12), .ctrl_reg(ctrl12), .cur_channel(cur12), .frame_done(fd12)
    );

    ad79x8_responder #(.RES_BITS(8), .NUM_CH(8)) dut8 (
        .sclk(sclk), .rst_n(rst_n), .cs(cs), .din(din), .dout(dout8), .dout_en(dout_en8),
        .ch_data(ch_data8), .ctrl_reg(ctrl8), .cur_channel(cur8), .frame_done(fd8)
    );

    logic [11:0] samp [NCH];

    // Reference model: frame-level view of the device
    bit          m_ready;
    int          m_pos;
    logic [15:0] m_rx;
    logic [11:0] m_ctrl;
    logic [2:0]  m_cur;
    bit          m_sact;
    logic [2:0]  m_slast;
    logic [15:0] m_word12, m_word8;
    bit          m_fd;

    logic        e_dout12, e_dout8, e_en, e_fd;
    logic [11:0] e_ctrl;
    logic [2:0]  e_cur;
    bit          chk_en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_seen = 0;

    function automatic void m_reset();
        m_ready = 1'b0; m_pos = 0; m_rx = '0; m_ctrl = 12'h031; m_cur = '0;
        m_sact = 1'b0; m_slast = '0; m_word12 = '0; m_word8 = '0; m_fd = 1'b0;
    endfunction

    function automatic logic [15:0] m_load(input logic [2:0] ch, input int res);
        logic [11:0] s;
        if (m_ctrl[5:4] == 2'b10) begin
            s = '0;
        end else begin
            s = (res == 12) ? samp[ch] : {samp[ch][11:4], 4'h0};
            if (!m_ctrl[0]) s[11] = ~s[11];
        end
        return {1'b0, ch, s};
    endfunction

    function automatic void m_frame_end();
        logic [11:0] cw;
        logic [2:0]  nxt;
        cw = m_rx[15:4];
        if (cw[11]) begin
            m_ctrl = cw;
            if (cw[10] && !cw[3]) begin
                m_sact = 1'b1; m_slast = cw[8:6]; nxt = 3'd0;
            end else begin
                m_sact = 1'b0; nxt = cw[8:6];
            end
        end else if (m_sact) begin
            nxt = (m_cur == m_slast) ? 3'd0 : m_cur + 3'd1;
        end else begin
            nxt = m_cur;
        end
        m_cur    = nxt;
        m_word12 = m_load(nxt, 12);
        m_word8  = m_load(nxt, 8);
        m_fd     = 1'b1;
    endfunction

    function automatic void m_step(input logic c, input logic d, input logic r);
        m_fd = 1'b0;
        if (!r) begin
            m_reset();
        end else if (!m_ready) begin
            if (c) m_ready = 1'b1;
        end else if (c) begin
            m_pos = 0;
        end else begin
            m_rx = {m_rx[14:0], d};
            m_pos++;
            if (m_pos == 16) begin
                m_pos = 0;
                m_frame_end();
            end
        end
    endfunction

    function automatic void m_expect();
        logic on;
        on       = m_ready && !cs;
        e_en     = on;
        e_dout12 = on & m_word12[15-m_pos];
        e_dout8  = on & m_word8[15-m_pos];
        e_fd     = m_fd;
        e_ctrl   = m_ctrl;
        e_cur    = m_cur;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge sclk) begin
        if (chk_en) begin
            check("dout12",    16'(dout12),    16'(e_dout12));
            check("dout_en12", 16'(dout_en12), 16'(e_en));
            check("fd12",      16'(fd12),      16'(e_fd));
            check("ctrl12",    16'(ctrl12),    16'(e_ctrl));
            check("cur12",     16'(cur12),     16'(e_cur));
            check("dout8",     16'(dout8),     16'(e_dout8));
            check("dout_en8",  16'(dout_en8),  16'(e_en));
            check("fd8",       16'(fd8),       16'(e_fd));
            check("ctrl8",     16'(ctrl8),     16'(e_ctrl));
            check("cur8",      16'(cur8),      16'(e_cur));
            if (fd12) fd_seen++;
        end
    end

    task automatic tick(input logic c, input logic d, output logic b12, output logic b8);
        cs  = c;
        din = d;
        m_expect();
        chk_en = 1'b1;
        @(negedge sclk);
        b12 = dout12;
        b8  = dout8;
        @(posedge sclk);
        m_step(c, d, rst_n);
        #1;
    endtask

    task automatic idle(input int n);
        logic b12, b8;
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, b12, b8);
    endtask

    task automatic frame(input logic [15:0] w, input int nbits,
                         output logic [15:0] got12, output logic [15:0] got8);
        logic b12, b8;
        got12 = '0;
        got8  = '0;
        for (int i = 0; i < nbits; i++) begin
            tick(1'b0, w[15-i], b12, b8);
            got12[15-i] = b12;
            got8[15-i]  = b8;
        end
        idle(2);
    endtask

    initial begin
        logic [15:0] g12, g8, p12, p8;
        logic        b12, b8;
        int          fd0;
        int          exp_addr [5];
        logic [15:0] pw;

        exp_addr = '{0, 1, 2, 0, 1};
        samp = '{12'h0F1, 12'h1E2, 12'h2D3, 12'h3C4, 12'h4B5, 12'hABC, 12'h697, 12'h788};
        for (int n = 0; n < NCH; n++) begin
            ch_data12[n*12 +: 12] = samp[n];
            ch_data8[n*8 +: 8]    = samp[n][11:4];
        end

        rst_n = 1'b0; cs = 1'b1; din = 1'b0;
        m_reset();
        @(posedge sclk); #1;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        check("rst_ctrl",    16'(ctrl12),    16'h0031);
        check("rst_dout_en", 16'(dout_en12), 16'h0000);
        check("rst_cur",     16'(cur12),     16'h0000);

        // Scenario 1: idle frame after reset
        fd0 = fd_seen;
        frame(16'h0000, 16, g12, g8);
        check("s1_word",  g12, 16'h0000);
        check("s1_fd",    16'(fd_seen - fd0), 16'h0001);
        check("s1_ctrl",  16'(ctrl12), 16'h0031);

        // Scenario 2: addressed write to channel 5, straight binary
        frame(16'h9710, 16, g12, g8);
        frame(16'h0000, 16, g12, g8);
        check("s2_word12", g12, 16'h5ABC);
        check("s2_word8",  g8,  16'h5AB0);
        check("s2_cur",    16'(cur12), 16'h0005);

        // Scenario 3: two's complement coding, then full shutdown
        frame(16'h9700, 16, g12, g8);
        frame(16'h0000, 16, g12, g8);
        check("s3_word12", g12, 16'h52BC);
        check("s3_word8",  g8,  16'h52B0);
        frame(16'h9610, 16, g12, g8);
        frame(16'h0000, 16, g12, g8);
        check("s3_pmsd12", g12, 16'h5000);
        check("s3_pmsd8",  g8,  16'h5000);

        // Scenario 4: sequence 0..2 repeating
        frame(16'hCB10, 16, g12, g8);
        for (int k = 0; k < 5; k++) begin
            frame(16'h0000, 16, g12, g8);
            check($sformatf("s4_addr%0d", k), 16'(g12[14:12]), 16'(exp_addr[k]));
        end

        // Scenario 5: aborted frame leaves state alone and the result is resent
        fd0 = fd_seen;
        frame(16'h9710, 8, p12, p8);
        check("s5_ctrl",  16'(ctrl12), 16'h0CB1);
        check("s5_nofd",  16'(fd_seen - fd0), 16'h0000);
        check("s5_part",  16'(p12[15:8]), 16'h0022);
        frame(16'h0000, 16, g12, g8);
        check("s5_resend", g12, 16'h22D3);

        // Scenario 6: reset mid-frame after edge 10
        pw = 16'h9710;
        for (int i = 0; i < 10; i++) tick(1'b0, pw[15-i], b12, b8);
        rst_n = 1'b0;
        m_reset();
        #1;
        check("s6_ctrl",    16'(ctrl12),    16'h0031);
        check("s6_dout_en", 16'(dout_en12), 16'h0000);
        check("s6_cur",     16'(cur12),     16'h0000);
        tick(1'b0, pw[5], b12, b8);
        rst_n = 1'b1;
        for (int i = 11; i < 16; i++) tick(1'b0, pw[15-i], b12, b8);
        idle(2);
        fd0 = fd_seen;
        frame(16'h0000, 16, g12, g8);
        check("s6_word", g12, 16'h0000);
        check("s6_fd",   16'(fd_seen - fd0), 16'h0001);
        check("s6_ctrl2", 16'(ctrl12), 16'h0031);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
